am2909_sequencer: RTL and testbench
===================================

// Module: am2909_sequencer
// PURPOSE
//   4-bit microprogram sequencer slice (Am2909 behaviour) producing microcode addresses for the
//   control store whose fields (A/B select, source, op, dest, carry) drive the ALU slices.
//   Slices cascade via cin/cout to form wider addresses. Active-low pins become active-high.
//   The tristate output enable is dropped, so yout is always driven.
// PARAMETERS
//   STACK_DEPTH  4  return-address stack depth; power of 2, >=2; SPW = log2(STACK_DEPTH)
// PORTS
//   clock       in   1    rising-edge clock
//   reset       in   1    asynchronous, active-high reset
//   din         in   4    direct branch address input (source 3)
//   rin         in   4    address register load input
//   regLoad     in   1    1: AR <= rin at clock edge
//   srcSel      in   2    0=uPC, 1=AR, 2=stack top, 3=din
//   orIn        in   4    OR-ed into the selected address (multiway branch)
//   zero        in   1    1: forces yout=0 (overrides orIn)
//   fileEnable  in   1    1: perform stack op selected by push at clock edge
//   push        in   1    with fileEnable: 1=push uPC, 0=pop
//   cin         in   1    incrementer carry in (1 = advance)
//   yout        out  4    next microcode address
//   cout        out  1    incrementer carry out for next slice
//   stackPtr    out  SPW  current stack pointer (debug/verification)
// BEHAVIOUR
//   State: uPC[3:0], AR[3:0], SP[SPW-1:0], file[STACK_DEPTH][3:0].
//   Reset (async, any time incl. mid-op): uPC=0, AR=0, SP=0, all file entries=0.
//     Hence yout=0 for srcSel 0/1/2, cout=0 when orIn=0/zero=0; stackPtr=0.
//   Combinational (zero latency):
//     mux  = srcSel: uPC | AR | file[SP] | din
//     yout = zero ? 0 : (mux | orIn)
//     {cout, inc} = yout + cin (5-bit sum); cout=1 only for yout=4'hF and cin=1.
//   At rising clock edge (no reset asserted):
//     uPC <= inc (4 bits; F+1 wraps to 0, carry goes out on cout).
//     regLoad=1: AR <= rin; else AR holds.
//     fileEnable=1 & push=1: SP <= SP+1 (mod depth); file[SP+1] <= current uPC (pre-increment value).
//     fileEnable=1 & push=0: SP <= SP-1 (mod depth); contents unchanged.
//     fileEnable=0: SP and file hold; push ignored.
//   Simultaneous events:
//     srcSel=2 with pop in same cycle: yout = top before pop (return executes the popped address).
//     srcSel=2 with push: yout = top before push; new entry visible next cycle.
//     Push while srcSel=0: stored value is uPC (the return address); uPC still advances to yout+cin.
//     regLoad and srcSel=1 together: yout uses old AR; new AR is visible next cycle.
//   Overflow/underflow: no detection. The pointer wraps mod STACK_DEPTH and the oldest entry
//     is overwritten on the 5th push (depth 4). A pop from SP=0 goes to SP=STACK_DEPTH-1.
//   cin=0 holds uPC at yout (wait/repeat loop).
//   No X on outputs after reset; all paths fully assigned.
// TESTING
//   1 Reset, srcSel=0, cin=1 for 20 clocks -> yout 0,1,...,F,0,1,2,3; cout=1 only on the F cycle.
//   2 din=9, srcSel=3, fileEnable=1, push=1 (uPC=4) -> yout=9, next SP=1, file[1]=4;
//     next cycle srcSel=2, pop -> yout=4, SP=0, then uPC=5.
//   3 srcSel=1, rin=6, regLoad=1 -> yout=old AR(0) that cycle; next cycle yout=6.
//     orIn=1 gives 7; zero=1 gives 0.
//   4 Five pushes at uPC=1..5 then four pops with srcSel=2 -> tops read 5,4,3,2.
//     Entry 1 was overwritten; stackPtr walks 1,2,3,0,1 then 0,3,2,1.
//   5 Assert reset asynchronously mid-cycle after pushes/AR load -> yout=0, stackPtr=0
//     immediately, with no clock edge needed.
//   6 Two slices cascaded (low cout->high cin), srcSel=3, din=8'h0F, then srcSel=0, cin=1
//     -> next address 8'h10; then 8'hFF wraps to 8'h00 with high cout=1.

Source files
------------

// File: rtl/am2909_sequencer_if.sv
// Bus bundle for one 4-bit Am2909 sequencer slice: control-store fields in,
// next microcode address, carry and stack pointer out.
interface am2909_sequencer_if #(
  parameter int STACK_DEPTH = 4
);
  localparam int SPW = $clog2(STACK_DEPTH);

  logic [3:0]     din;
  logic [3:0]     rin;
  logic           regLoad;
  logic [1:0]     srcSel;
  logic [3:0]     orIn;
  logic           zero;
  logic           fileEnable;
  logic           push;
  logic           cin;
  logic [3:0]     yout;
  logic           cout;
  logic [SPW-1:0] stackPtr;

  // Microcode side: drives the field inputs and consumes the address.
  modport master (
    output din, rin, regLoad, srcSel, orIn, zero, fileEnable, push, cin,
    input  yout, cout, stackPtr
  );

  // Sequencer side.
  modport slave (
    input  din, rin, regLoad, srcSel, orIn, zero, fileEnable, push, cin,
    output yout, cout, stackPtr
  );
endinterface

// File: rtl/am2909_sequencer.sv
// 4-bit microprogram sequencer slice with Am2909 behaviour. The next address
// is chosen from uPC, the address register, the stack top or din, OR-ed with
// orIn (or forced to zero), and incremented into uPC. Slices cascade through
// cin/cout. A small return-address stack wraps silently on over/underflow.
module am2909_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  am2909_sequencer_if.slave bus
);
  localparam int SPW = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    SRC_UPC   = 2'd0,
    SRC_AR    = 2'd1,
    SRC_STACK = 2'd2,
    SRC_DIN   = 2'd3
  } src_sel_e;

  logic [3:0]     upc;
  logic [3:0]     ar;
  logic [SPW-1:0] sp;
  logic [3:0]     stack_q [STACK_DEPTH];

  logic [3:0]     mux_addr;
  logic [3:0]     next_addr;
  logic [3:0]     inc;
  logic           carry;
  logic [SPW-1:0] sp_inc;
  logic [SPW-1:0] sp_dec;

  assign sp_inc = sp + 1'b1;
  assign sp_dec = sp - 1'b1;

  // Address source select, OR/zero forcing and incrementer (zero latency).
  always_comb begin
    mux_addr = upc;
    unique case (src_sel_e'(bus.srcSel))
      SRC_UPC:   mux_addr = upc;
      SRC_AR:    mux_addr = ar;
      SRC_STACK: mux_addr = stack_q[sp];
      SRC_DIN:   mux_addr = bus.din;
      default:   mux_addr = upc;
    endcase
    next_addr    = bus.zero ? 4'h0 : (mux_addr | bus.orIn);
    {carry, inc} = {1'b0, next_addr} + {4'h0, bus.cin};
  end

  assign bus.yout     = next_addr;
  assign bus.cout     = carry;
  assign bus.stackPtr = sp;

  // Microprogram counter, address register and stack pointer.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values; reads of uPC/AR/SP this cycle always see old state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc <= 4'h0;
      ar  <= 4'h0;
      sp  <= '0;
    end else begin
      upc <= inc;
      if (bus.regLoad) ar <= bus.rin;
      if (bus.fileEnable) sp <= bus.push ? sp_inc : sp_dec;
    end
  end

  // Return-address stack: push writes the pre-increment uPC above the current top.
  // NOTE: the stack is a tiny flop array, so it is cleared on reset to keep the
  // stack-top path X-free; a large RAM would normally be left unreset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 4'h0;
    end else if (bus.fileEnable && bus.push) begin
      stack_q[sp_inc] <= upc;
    end
  end
endmodule

// File: tb/tb_am2909_sequencer.sv
// Self-checking bench for am2909_sequencer: expected outputs are queued as each
// stimulus is applied and popped/compared when the outputs are sampled.
module tb_am2909_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  am2909_sequencer_if #(.STACK_DEPTH(4)) bus_lo ();
  am2909_sequencer_if #(.STACK_DEPTH(4)) bus_hi ();

  am2909_sequencer #(.STACK_DEPTH(4)) u_lo (.clock(clock), .reset(reset), .bus(bus_lo));
  am2909_sequencer #(.STACK_DEPTH(4)) u_hi (.clock(clock), .reset(reset), .bus(bus_hi));

  assign bus_hi.cin = bus_lo.cout;

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    bit         casc;
    logic [7:0] y;
    logic       c;
    logic [1:0] sp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one set of field inputs to both slices (din is the 8-bit cascade value).
  task automatic drive(input logic [1:0] src, input logic [7:0] d, input logic [3:0] r,
                       input logic rl, input logic [3:0] orv, input logic z,
                       input logic fe, input logic pu, input logic ci);
    bus_lo.srcSel = src;  bus_hi.srcSel = src;
    bus_lo.din = d[3:0];  bus_hi.din = d[7:4];
    bus_lo.rin = r;       bus_hi.rin = 4'h0;
    bus_lo.regLoad = rl;  bus_hi.regLoad = 1'b0;
    bus_lo.orIn = orv;    bus_hi.orIn = 4'h0;
    bus_lo.zero = z;      bus_hi.zero = 1'b0;
    bus_lo.fileEnable = fe; bus_hi.fileEnable = 1'b0;
    bus_lo.push = pu;     bus_hi.push = 1'b0;
    bus_lo.cin = ci;
  endtask

  task automatic expect_lo(input string tag, input logic [3:0] y, input logic c, input logic [1:0] sp);
    exp_t e;
    e.tag = tag; e.casc = 1'b0; e.y = {4'h0, y}; e.c = c; e.sp = sp;
    sb_q.push_back(e);
  endtask

  task automatic expect_casc(input string tag, input logic [7:0] y, input logic c);
    exp_t e;
    e.tag = tag; e.casc = 1'b1; e.y = y; e.c = c; e.sp = 2'd0;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic sample();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = sb_q.pop_front();
    if (e.casc) begin
      check({e.tag, ".y"}, {bus_hi.yout, bus_lo.yout}, e.y);
      check({e.tag, ".cout"}, {7'h0, bus_hi.cout}, {7'h0, e.c});
    end else begin
      check({e.tag, ".y"}, {4'h0, bus_lo.yout}, e.y);
      check({e.tag, ".cout"}, {7'h0, bus_lo.cout}, {7'h0, e.c});
      check({e.tag, ".sp"}, {6'h0, bus_lo.stackPtr}, {6'h0, e.sp});
    end
  endtask

  // Sample on the falling edge, then advance through the rising edge.
  task automatic cycle();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    expect_lo("reset_state", 4'h0, 1'b0, 2'd0);
    sample();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: free-running count, carry only on F.
    for (int i = 0; i < 20; i++) begin
      expect_lo($sformatf("count%0d", i), 4'(i % 16), (i % 16) == 15, 2'd0);
      cycle();
    end

    // 2: jump with push (uPC=4), then return via pop.
    drive(2'd3, 8'h09, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_lo("jump_push", 4'h9, 1'b0, 2'd0);
    cycle();
    drive(2'd2, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_lo("return_pop", 4'h4, 1'b0, 2'd1);
    cycle();
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("after_return", 4'h5, 1'b0, 2'd0);
    cycle();

    // 3: address register load, OR and zero forcing.
    drive(2'd1, 8'h00, 4'h6, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("ar_old", 4'h0, 1'b0, 2'd0);
    cycle();
    drive(2'd1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("ar_new", 4'h6, 1'b0, 2'd0);
    cycle();
    drive(2'd1, 8'h00, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("ar_or", 4'h7, 1'b0, 2'd0);
    cycle();
    drive(2'd1, 8'h00, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_lo("zero_force", 4'h0, 1'b0, 2'd0);
    cycle();

    // cin=0 holds uPC (wait loop).
    drive(2'd3, 8'h03, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("load3", 4'h3, 1'b0, 2'd0);
    cycle();
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      expect_lo($sformatf("hold%0d", i), 4'h4, 1'b0, 2'd0);
      cycle();
    end

    // 4: five pushes at uPC=1..5 (overflow), four pops reading 5,4,3,2.
    drive(2'd3, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("load0", 4'h0, 1'b0, 2'd0);
    cycle();
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_lo($sformatf("push%0d", i), 4'(i + 1), 1'b0, 2'(i));
      cycle();
    end
    drive(2'd2, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    begin
      logic [3:0] tops [4] = '{4'h5, 4'h4, 4'h3, 4'h2};
      logic [1:0] sps  [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
      for (int i = 0; i < 4; i++) begin
        expect_lo($sformatf("pop%0d", i), tops[i], 1'b0, sps[i]);
        cycle();
      end
    end
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("after_pops", 4'h3, 1'b0, 2'd1);
    cycle();

    // 5: asynchronous reset mid-cycle.
    drive(2'd1, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    expect_lo("pre_reset_ar", 4'h6, 1'b0, 2'd1);
    sample();
    reset = 1'b1;
    #1;
    expect_lo("async_reset_ar", 4'h0, 1'b0, 2'd0);
    sample();
    drive(2'd2, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    expect_lo("async_reset_stack", 4'h0, 1'b0, 2'd0);
    sample();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_lo("post_reset_upc", 4'h0, 1'b0, 2'd0);
    cycle();

    // 6: two cascaded slices.
    drive(2'd3, 8'h0F, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_casc("casc_0f", 8'h0F, 1'b0);
    cycle();
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_casc("casc_10", 8'h10, 1'b0);
    cycle();
    drive(2'd3, 8'hFF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_casc("casc_ff", 8'hFF, 1'b1);
    cycle();
    drive(2'd0, 8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_casc("casc_wrap", 8'h00, 1'b0);
    cycle();

    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
